// File: rtl/loader_defs.sv
// Shared definitions for the instruction-memory loader: frame header,
// FSM state encodings and the default inter-byte timeout.
package loader_defs;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned CNT_W           = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 1000000;

    localparam logic [BYTE_W-1:0] HEADER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in from the UART receiver and word writes out to instruction memory.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master is the loader; slave is the UART/memory side
    modport master (
        input  rx_data,
        input  rx_valid,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/word_assembler.sv
// Packs big-endian bytes into 32-bit words; flags the cycle the 4th byte arrives.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_c,
    output logic [31:0] word_c
);

    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    // only the three earlier bytes need storing; the 4th is taken straight from the input
    assign word_done_c = valid_i && (idx_q == 2'd3);
    assign word_c      = {shift_q, byte_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (valid_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives framed program images over a byte stream, writes them into
// instruction memory and holds the CPU until a frame checks out.
module imem_loader
    import loader_defs::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [ADDR_W:0] words_loaded
);

    localparam int unsigned WL_W  = ADDR_W + 1;
    localparam int unsigned CMP_W = (WL_W > CNT_W + 1) ? WL_W : CNT_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CMP_W-1:0] MAX_CNT = CMP_W'(1) << ADDR_W;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [BYTE_W-1:0]   chk_q, chk_d;
    logic [WL_W-1:0]     wl_q, wl_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;

    logic                asm_clr_c, asm_valid_c, asm_done_c;
    logic [WORD_W-1:0]   asm_word_c;
    logic                in_frame_c, all_written_c;
    logic [CNT_W-1:0]    rx_count_c;

    word_assembler u_asm (
        .clk         (clk),
        .rst_n       (reset),
        .clr_i       (asm_clr_c),
        .valid_i     (asm_valid_c),
        .byte_i      (bus.rx_data),
        .word_done_c (asm_done_c),
        .word_c      (asm_word_c)
    );

    assign in_frame_c    = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
                           (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign all_written_c = (CMP_W'(wl_q) == CMP_W'(count_q));
    assign rx_count_c    = {cnt_hi_q, bus.rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_hi_q <= '0;
            count_q  <= '0;
            chk_q    <= '0;
            wl_q     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            to_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            count_q  <= count_d;
            chk_q    <= chk_d;
            wl_q     <= wl_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            to_q     <= to_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        count_d     = count_q;
        chk_d       = chk_q;
        wl_d        = wl_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        to_d        = '0;
        asm_clr_c   = 1'b0;
        asm_valid_c = 1'b0;

        if (in_frame_c) begin
            to_d = bus.rx_valid ? '0 : to_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.rx_valid && (bus.rx_data == HEADER)) begin
                    state_d   = ST_CNT_HI;
                    wl_d      = '0;
                    chk_d     = '0;
                    asm_clr_c = 1'b1;
                end
            end
            ST_CNT_HI: begin
                if (bus.rx_valid) begin
                    cnt_hi_d = bus.rx_data;
                    chk_d    = chk_q ^ bus.rx_data;
                    state_d  = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (bus.rx_valid) begin
                    count_d = rx_count_c;
                    chk_d   = chk_q ^ bus.rx_data;
                    if ((rx_count_c == '0) || (CMP_W'(rx_count_c) > MAX_CNT)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // last write cycle: a byte arriving now is already the checksum
                if (we_q && all_written_c) begin
                    if (bus.rx_valid) begin
                        state_d = (bus.rx_data == chk_q) ? ST_DONE : ST_ERR;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else if (bus.rx_valid) begin
                    asm_valid_c = 1'b1;
                    chk_d       = chk_q ^ bus.rx_data;
                    if (asm_done_c) begin
                        we_d    = 1'b1;
                        addr_d  = wl_q[ADDR_W-1:0];
                        wdata_d = asm_word_c;
                        wl_d    = wl_q + WL_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == chk_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // a stalled stream abandons the frame; nothing further is written
        if (in_frame_c && (to_q >= TO_W'(TIMEOUT_CYC))) begin
            state_d = ST_ERR;
            we_d    = 1'b0;
            wl_d    = wl_q;
        end

        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
        hold_d = (state_d != ST_DONE);
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_hold       = hold_q;
    assign done           = done_q;
    assign error          = err_q;
    assign words_loaded   = wl_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
REQ-002 Parameter TIMEOUT_CYC, default 1000000: maximum clk cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle; no backpressure.
REQ-007 imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-008 imem_addr  output  ADDR_W  word address of the current write.
REQ-009 imem_wdata  output  32  instruction word to write.
REQ-010 cpu_hold  output  1  holds the CPU (PC and register writes) while high.
REQ-011 done  output  1  last frame loaded and checksum matched.
REQ-012 error  output  1  last frame aborted.
REQ-013 words_loaded  output  ADDR_W+1  count of words written in the current or last frame.

Function
REQ-014 Frame format SHALL be: header 0xA5, count high byte, count low byte, count x 4 data bytes (each word big-endian, MSB first), then 1 checksum byte.
REQ-015 The checksum SHALL be the XOR of both count bytes and all data bytes; the header is excluded.
REQ-016 FSM states SHALL be IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERR.
REQ-017 IDLE, DONE and ERR SHALL discard every byte except 0xA5.
REQ-018 0xA5 in IDLE, DONE or ERR SHALL move to CNT_HI, clear words_loaded and the checksum, and hold done=0, error=0, cpu_hold=1.
REQ-019 CNT_HI SHALL latch the next byte and go to CNT_LO.
REQ-020 CNT_LO SHALL latch the low byte, then check the count.
REQ-021 A count of 0 or greater than 2^ADDR_W SHALL go to ERR; any other count SHALL go to DATA.
REQ-022 In DATA, bytes SHALL shift into a 32-bit register under a 2-bit byte counter.
REQ-023 The cycle after the 4th byte of a word, imem_we SHALL be 1 for exactly one cycle, with imem_addr = words_loaded[ADDR_W-1:0] and imem_wdata = the assembled word.
REQ-024 words_loaded SHALL increment in the same cycle as that imem_we pulse.
REQ-025 After the last word's write, the FSM SHALL go to CHECK.
REQ-026 In CHECK, a received byte equal to the checksum SHALL go to DONE; any other byte SHALL go to ERR.
REQ-027 In DONE: done=1, cpu_hold=0. In ERR: error=1, cpu_hold=1. In all other states: done=0, error=0, cpu_hold=1.
REQ-028 In CNT_HI, CNT_LO, DATA and CHECK, a counter SHALL clear on every rx_valid; when it reaches TIMEOUT_CYC the FSM SHALL go to ERR.
REQ-029 A 0xA5 byte inside a frame SHALL be treated as data, not as a new header.
REQ-030 Words already written before an ERR SHALL stay in memory; words_loaded SHALL report how many were written.
REQ-031 Because the write strobe is registered one cycle behind the byte, an rx_valid that arrives in the same cycle as that write SHALL still be accepted.
REQ-032 imem_we SHALL never assert outside DATA.

Reset
REQ-033 Asserting reset (low) SHALL asynchronously force: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, done=0, error=0, cpu_hold=1, checksum=0, all counters=0.
REQ-034 Reset in the middle of a frame SHALL abandon the frame with no further writes; the next frame SHALL need a fresh 0xA5.

Structure
REQ-035 The header value, state encodings and the default TIMEOUT_CYC SHALL live in a shared definitions file, loader_defs, used by this block and by the bench.
REQ-036 Byte-to-word assembly (shift register plus byte counter) SHALL be one sub-module, word_assembler; the FSM, timeout and checksum logic stay in imem_loader.

Verification
REQ-037 Send A5 00 02 20 08 00 05 00 00 00 00 and checksum 0x2F -> writes [0]=0x20080005, [1]=0x00000000; done=1; cpu_hold=0; words_loaded=2.
REQ-038 Send the same frame with checksum 0x00 -> both writes occur; error=1; cpu_hold=1; done=0.
REQ-039 Send A5 00 00 -> ERR with no writes. Then send A5 01 01 (count 257, ADDR_W=8) -> ERR with no writes.
REQ-040 Send A5 00 01 11 22, then stay idle for TIMEOUT_CYC cycles (set to 50) -> error=1, no imem_we.
REQ-041 Send 3C 3C before A5 00 01 A5 A5 A5 A5 and checksum 0x01 -> leading bytes ignored; [0]=0xA5A5A5A5; done=1.
REQ-042 Assert reset after 2 data bytes, release it, then send a full valid frame -> no write from the aborted frame; new frame loads correctly; also check rx_valid on back-to-back cycles.
